// File: rtl/tl_rx_vc_read_arbiter_pkg.sv
// Shared types, field positions and helpers for the RX VC buffer read side.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package tl_rx_vc_pkg;

    localparam int DW               = 32;
    localparam int R_CTRL_BUS_WIDTH = 6;
    localparam int FLAGS_WIDTH      = 6;
    localparam int BEAT_SIZE        = 32 * DW;
    localparam int REQ_HDR_SIZE     = 4 * DW;
    localparam int CPL_HDR_SIZE     = 3 * DW;

    // Read control bus bits.
    localparam int HDR_RD_BIT  = 0;
    localparam int DATA_RD_BIT = 1;

    // DW0 field positions (DW0 sits in the header MSBs).
    localparam int FMT_DATA_BIT = 30;
    localparam int LEN_MSB      = 9;

    // Empty-flag vector {p_hdr, p_data, np_hdr, np_data, cpl_hdr, cpl_data}.
    localparam int P_HDR_EMPTY     = 5;
    localparam int P_DATA_EMPTY    = 4;
    localparam int NP_HDR_EMPTY    = 3;
    localparam int NP_DATA_EMPTY   = 2;
    localparam int CPL_HDR_EMPTY   = 1;
    localparam int CPL_DATA_EMPTY  = 0;

    typedef enum logic [1:0] {
        CLS_P   = 2'd0,
        CLS_NP  = 2'd1,
        CLS_CPL = 2'd2
    } tlp_class_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } arb_state_e;

    // Length field in DW to 32-DW beats; a zero length encodes 1024 DW.
    function automatic logic [5:0] len_to_beats(input logic [LEN_MSB:0] len);
        if (len == '0) begin
            return 6'd32;
        end
        return 6'(({1'b0, len} + 11'd31) >> 5);
    endfunction

    // Class following c in round-robin order, CPL wrapping to P.
    function automatic tlp_class_e next_class(input tlp_class_e c);
        case (c)
            CLS_P:   return CLS_NP;
            CLS_NP:  return CLS_CPL;
            default: return CLS_P;
        endcase
    endfunction

endpackage

// File: rtl/tl_rx_vc_read_arbiter_if.sv
// TLP stream from the VC read arbiter to the downstream RX consumer.
// Latency: n/a (signal bundle).
// Backpressure: valid/ready; a beat holds until o_tlp_valid && i_tlp_ready.
interface tl_rx_vc_read_arbiter_if;
    import tl_rx_vc_pkg::*;

    logic                    o_tlp_valid;
    logic                    i_tlp_ready;
    logic [1:0]              o_tlp_type;
    logic                    o_tlp_sop;
    logic                    o_tlp_last;
    logic [REQ_HDR_SIZE-1:0] o_tlp_hdr;
    logic [BEAT_SIZE-1:0]    o_tlp_data;
    logic                    o_tlp_data_vld;

    modport master (
        output o_tlp_valid, o_tlp_type, o_tlp_sop, o_tlp_last,
               o_tlp_hdr, o_tlp_data, o_tlp_data_vld,
        input  i_tlp_ready
    );

    modport slave (
        input  o_tlp_valid, o_tlp_type, o_tlp_sop, o_tlp_last,
               o_tlp_hdr, o_tlp_data, o_tlp_data_vld,
        output i_tlp_ready
    );

endinterface

// File: rtl/tl_rx_vc_rr_arbiter.sv
// Three-way round-robin grant over P/NP/CPL with pointer advance on take.
// Latency: grant is combinational; pointer updates on the clock after take.
// Backpressure: pointer holds while take is low.
module tl_rx_vc_rr_arbiter
    import tl_rx_vc_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [2:0] req,
    input  logic       take,
    output logic       gnt_vld,
    output tlp_class_e gnt
);

    tlp_class_e ptr_q;

    // Grant the first requester at or after the pointer.
    always_comb begin
        gnt_vld = |req;
        gnt     = ptr_q;
        case (ptr_q)
            CLS_NP:  gnt = req[1] ? CLS_NP  : (req[2] ? CLS_CPL : CLS_P);
            CLS_CPL: gnt = req[2] ? CLS_CPL : (req[0] ? CLS_P   : CLS_NP);
            default: gnt = req[0] ? CLS_P   : (req[1] ? CLS_NP  : CLS_CPL);
        endcase
    end

    // Pointer moves just past the class that was taken.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_q <= CLS_P;
        end else if (take && gnt_vld) begin
            ptr_q <= next_class(gnt);
        end
    end

endmodule

// File: rtl/tl_rx_vc_read_arbiter.sv
// Picks one TLP class from the RX VC buffers, pops header + data beats, streams them out (TL_RX_VC_ARB_P_PRIORITY_EN: strict P>CPL>NP).
// Latency: 1 cycle grant (IDLE->HDR), then one beat per cycle; outputs combinational from FWFT heads.
// Backpressure: ready low or data empty holds the beat and issues no pops; no TLP interleaving.
module tl_rx_vc_read_arbiter
    import tl_rx_vc_pkg::*;
(
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [FLAGS_WIDTH-1:0]      i_vc_r_empty_flags,
    output logic [R_CTRL_BUS_WIDTH-1:0] o_r_posted_ctrl,
    output logic [R_CTRL_BUS_WIDTH-1:0] o_r_non_posted_ctrl,
    output logic [R_CTRL_BUS_WIDTH-1:0] o_r_completion_ctrl,
    input  logic [REQ_HDR_SIZE-1:0]     i_r_posted_hdr,
    input  logic [REQ_HDR_SIZE-1:0]     i_r_non_posted_hdr,
    input  logic [CPL_HDR_SIZE-1:0]     i_r_completion_hdr,
    input  logic [BEAT_SIZE-1:0]        i_r_posted_data,
    input  logic [BEAT_SIZE-1:0]        i_r_non_posted_data,
    input  logic [BEAT_SIZE-1:0]        i_r_completion_data,
    tl_rx_vc_read_arbiter_if.master     tlp
);

    arb_state_e state_q, state_d;
    tlp_class_e sel_q, sel_d;
    logic [5:0] cnt_q, cnt_d;

    logic [2:0] req;
    logic       gnt_vld;
    tlp_class_e gnt;

    logic [REQ_HDR_SIZE-1:0] sel_hdr;
    logic [BEAT_SIZE-1:0]    sel_data;
    logic                    sel_data_empty;
    logic                    has_data;
    logic [5:0]              beats;

    logic                    out_valid, out_sop, out_last, out_dvld;
    logic [1:0]              out_type;
    logic [REQ_HDR_SIZE-1:0] out_hdr;
    logic [BEAT_SIZE-1:0]    out_data;
    logic                    hdr_pop, data_pop;

    assign req = {~i_vc_r_empty_flags[CPL_HDR_EMPTY],
                  ~i_vc_r_empty_flags[NP_HDR_EMPTY],
                  ~i_vc_r_empty_flags[P_HDR_EMPTY]};

`ifdef TL_RX_VC_ARB_P_PRIORITY_EN
    // Posted always overtakes pending completions and non-posted requests.
    always_comb begin
        gnt_vld = |req;
        gnt     = req[0] ? CLS_P : (req[2] ? CLS_CPL : CLS_NP);
    end
`else
    tl_rx_vc_rr_arbiter u_rr (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .req     (req),
        .take    (state_q == ST_IDLE),
        .gnt_vld (gnt_vld),
        .gnt     (gnt)
    );
`endif

    // Route the granted class's FWFT heads; CPL header sits in the MSBs.
    always_comb begin
        sel_hdr        = i_r_posted_hdr;
        sel_data       = i_r_posted_data;
        sel_data_empty = i_vc_r_empty_flags[P_DATA_EMPTY];
        case (sel_q)
            CLS_NP: begin
                sel_hdr        = i_r_non_posted_hdr;
                sel_data       = i_r_non_posted_data;
                sel_data_empty = i_vc_r_empty_flags[NP_DATA_EMPTY];
            end
            CLS_CPL: begin
                sel_hdr        = {i_r_completion_hdr, {(REQ_HDR_SIZE-CPL_HDR_SIZE){1'b0}}};
                sel_data       = i_r_completion_data;
                sel_data_empty = i_vc_r_empty_flags[CPL_DATA_EMPTY];
            end
            default: ;
        endcase
    end

    assign has_data = sel_hdr[REQ_HDR_SIZE-DW+FMT_DATA_BIT];
    assign beats    = len_to_beats(sel_hdr[REQ_HDR_SIZE-DW+LEN_MSB -: LEN_MSB+1]);

    // Next-state, beat outputs and pop strobes.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        out_valid = 1'b0;
        out_sop   = 1'b0;
        out_last  = 1'b0;
        out_dvld  = 1'b0;
        out_type  = 2'd0;
        out_hdr   = '0;
        out_data  = '0;
        hdr_pop   = 1'b0;
        data_pop  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    sel_d   = gnt;
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                out_type  = sel_q;
                out_hdr   = sel_hdr;
                out_data  = sel_data;
                out_sop   = 1'b1;
                out_dvld  = has_data;
                // First data beat travels with the header, so wait for it.
                out_valid = has_data ? !sel_data_empty : 1'b1;
                out_last  = !has_data || (beats == 6'd1);
                if (out_valid && tlp.i_tlp_ready) begin
                    hdr_pop  = 1'b1;
                    data_pop = has_data;
                    cnt_d    = has_data ? beats - 6'd1 : 6'd0;
                    state_d  = out_last ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                out_type  = sel_q;
                out_hdr   = sel_hdr;
                out_data  = sel_data;
                out_dvld  = 1'b1;
                out_valid = !sel_data_empty;
                out_last  = (cnt_q == 6'd1);
                if (out_valid && tlp.i_tlp_ready) begin
                    data_pop = 1'b1;
                    cnt_d    = cnt_q - 6'd1;
                    if (cnt_q == 6'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Reset abandons the TLP: nothing presented, nothing popped.
        if (i_rst) begin
            out_valid = 1'b0;
            out_sop   = 1'b0;
            out_last  = 1'b0;
            out_dvld  = 1'b0;
            out_type  = 2'd0;
            out_hdr   = '0;
            out_data  = '0;
            hdr_pop   = 1'b0;
            data_pop  = 1'b0;
        end
    end

    // Steer pop strobes onto the selected class's read control bus only.
    always_comb begin
        o_r_posted_ctrl     = '0;
        o_r_non_posted_ctrl = '0;
        o_r_completion_ctrl = '0;
        case (sel_q)
            CLS_NP: begin
                o_r_non_posted_ctrl[HDR_RD_BIT]  = hdr_pop;
                o_r_non_posted_ctrl[DATA_RD_BIT] = data_pop;
            end
            CLS_CPL: begin
                o_r_completion_ctrl[HDR_RD_BIT]  = hdr_pop;
                o_r_completion_ctrl[DATA_RD_BIT] = data_pop;
            end
            default: begin
                o_r_posted_ctrl[HDR_RD_BIT]  = hdr_pop;
                o_r_posted_ctrl[DATA_RD_BIT] = data_pop;
            end
        endcase
    end

    // State, selected class and remaining-beat counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            sel_q   <= CLS_P;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    assign tlp.o_tlp_valid    = out_valid;
    assign tlp.o_tlp_type     = out_type;
    assign tlp.o_tlp_sop      = out_sop;
    assign tlp.o_tlp_last     = out_last;
    assign tlp.o_tlp_hdr      = out_hdr;
    assign tlp.o_tlp_data     = out_data;
    assign tlp.o_tlp_data_vld = out_dvld;

endmodule

// File: tb/tb_tl_rx_vc_read_arbiter.sv
// Scoreboard bench for the RX VC read arbiter with FWFT buffer models.
// Latency: buffer pops applied 1 time unit after the clock edge that takes them.
// Backpressure: ready driven by the stimulus thread; stalls checked for hold.
module tb_tl_rx_vc_read_arbiter;
    import tl_rx_vc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [FLAGS_WIDTH-1:0]      flags;
    logic [R_CTRL_BUS_WIDTH-1:0] p_ctrl, np_ctrl, c_ctrl;
    logic [REQ_HDR_SIZE-1:0]     p_hdr, np_hdr;
    logic [CPL_HDR_SIZE-1:0]     c_hdr;
    logic [BEAT_SIZE-1:0]        p_data, np_data, c_data;

    tl_rx_vc_read_arbiter_if tlp_if ();

    tl_rx_vc_read_arbiter dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_vc_r_empty_flags  (flags),
        .o_r_posted_ctrl     (p_ctrl),
        .o_r_non_posted_ctrl (np_ctrl),
        .o_r_completion_ctrl (c_ctrl),
        .i_r_posted_hdr      (p_hdr),
        .i_r_non_posted_hdr  (np_hdr),
        .i_r_completion_hdr  (c_hdr),
        .i_r_posted_data     (p_data),
        .i_r_non_posted_data (np_data),
        .i_r_completion_data (c_data),
        .tlp                 (tlp_if.master)
    );

    typedef struct {
        logic [1:0]    typ;
        logic          sop;
        logic          last;
        logic          dvld;
        logic [127:0]  hdr;
        logic [1023:0] data;
    } beat_t;

    logic [REQ_HDR_SIZE-1:0] p_hq[$], np_hq[$];
    logic [CPL_HDR_SIZE-1:0] c_hq[$];
    logic [BEAT_SIZE-1:0]    p_dq[$], np_dq[$], c_dq[$];
    beat_t                   sb[$];

    int n_chk = 0, n_fail = 0;
    int hpops[3] = '{0, 0, 0};
    int dpops[3] = '{0, 0, 0};
    int beats_acc = 0, np_ctrl_hi = 0;
    logic [5:0] pc_s = '0, npc_s = '0, cc_s = '0;

    task automatic chk(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got[127:0], exp[127:0]);
        end
    endtask

    task automatic refresh();
        flags   = {p_hq.size() == 0, p_dq.size() == 0, np_hq.size() == 0,
                   np_dq.size() == 0, c_hq.size() == 0, c_dq.size() == 0};
        p_hdr   = (p_hq.size()  != 0) ? p_hq[0]  : '0;
        np_hdr  = (np_hq.size() != 0) ? np_hq[0] : '0;
        c_hdr   = (c_hq.size()  != 0) ? c_hq[0]  : '0;
        p_data  = (p_dq.size()  != 0) ? p_dq[0]  : '0;
        np_data = (np_dq.size() != 0) ? np_dq[0] : '0;
        c_data  = (c_dq.size()  != 0) ? c_dq[0]  : '0;
    endtask

    function automatic logic [1023:0] mk_data(input int cls, input logic [7:0] id, input int b);
        logic [31:0] w;
        w = {8'(cls), id, 16'(b)};
        return {32{w}};
    endfunction

    task automatic push_beat(input int cls, input logic [7:0] id, input int b);
        case (cls)
            0:       p_dq.push_back(mk_data(cls, id, b));
            1:       np_dq.push_back(mk_data(cls, id, b));
            default: c_dq.push_back(mk_data(cls, id, b));
        endcase
    endtask

    // Loads one TLP into the buffer model and its expected beats into the scoreboard.
    task automatic push_tlp(input int cls, input bit has_data, input logic [9:0] len,
                            input logic [7:0] id, input int ndata);
        logic [31:0]  dw0;
        logic [127:0] h;
        int           n;
        beat_t        e;
        dw0 = {1'b0, has_data, 2'b00, id, 10'h000, len};
        h   = {dw0, 24'h111111, id, 24'h222222, id, 24'h333333, id};
        if (cls == 2) h[31:0] = '0;
        n = has_data ? ((len == 0) ? 32 : (int'(len) + 31) / 32) : 1;
        case (cls)
            0:       p_hq.push_back(h);
            1:       np_hq.push_back(h);
            default: c_hq.push_back(h[127:32]);
        endcase
        for (int b = 0; b < n; b++) begin
            if (has_data && (ndata < 0 || b < ndata)) push_beat(cls, id, b);
            e.typ  = 2'(cls);
            e.sop  = (b == 0);
            e.last = (b == n - 1);
            e.dvld = has_data;
            e.hdr  = h;
            e.data = has_data ? mk_data(cls, id, b) : '0;
            sb.push_back(e);
        end
        refresh();
    endtask

    function automatic bit busy();
        return sb.size() != 0 || p_hq.size() != 0 || np_hq.size() != 0 || c_hq.size() != 0 ||
               p_dq.size() != 0 || np_dq.size() != 0 || c_dq.size() != 0;
    endfunction

    task automatic drain(input string tag, input int budget);
        int c = 0;
        while (busy() && c < budget) begin
            @(posedge clk);
            c++;
        end
        if (c >= budget) chk({tag, "_timeout"}, 0, 1);
        @(posedge clk);
        #2;
    endtask

    // Buffer model: apply the pops the DUT committed at this edge.
    always @(posedge clk) begin
        #1;
        if (pc_s[0])  begin chk("p_hdr_underflow",   p_hq.size()  != 0, 1); if (p_hq.size()  != 0) void'(p_hq.pop_front());  hpops[0]++; end
        if (pc_s[1])  begin chk("p_data_underflow",  p_dq.size()  != 0, 1); if (p_dq.size()  != 0) void'(p_dq.pop_front());  dpops[0]++; end
        if (npc_s[0]) begin chk("np_hdr_underflow",  np_hq.size() != 0, 1); if (np_hq.size() != 0) void'(np_hq.pop_front()); hpops[1]++; end
        if (npc_s[1]) begin chk("np_data_underflow", np_dq.size() != 0, 1); if (np_dq.size() != 0) void'(np_dq.pop_front()); dpops[1]++; end
        if (cc_s[0])  begin chk("c_hdr_underflow",   c_hq.size()  != 0, 1); if (c_hq.size()  != 0) void'(c_hq.pop_front());  hpops[2]++; end
        if (cc_s[1])  begin chk("c_data_underflow",  c_dq.size()  != 0, 1); if (c_dq.size()  != 0) void'(c_dq.pop_front());  dpops[2]++; end
        refresh();
    end

    logic          prev_stall = 1'b0;
    logic [1:0]    prev_type;
    logic          prev_sop, prev_last;
    logic [127:0]  prev_hdr;
    logic [1023:0] prev_data;

    // Monitor: exclusivity, stall hold, and scoreboard compare on accepted beats.
    always @(negedge clk) begin
        beat_t e;
        logic [5:0] ec;
        int nz;
        pc_s  = p_ctrl;
        npc_s = np_ctrl;
        cc_s  = c_ctrl;
        if (!rst) begin
            nz = int'(p_ctrl != 0) + int'(np_ctrl != 0) + int'(c_ctrl != 0);
            if (nz != 0) begin
                chk("ctrl_one_class", nz, 1);
                chk("ctrl_upper_zero", {p_ctrl[5:2], np_ctrl[5:2], c_ctrl[5:2]}, 0);
            end
            if (np_ctrl == 6'b000001) np_ctrl_hi++;
            if (!tlp_if.i_tlp_ready) chk("stall_no_pop", {p_ctrl, np_ctrl, c_ctrl}, 0);
            if (prev_stall) begin
                chk("hold_valid", tlp_if.o_tlp_valid, 1);
                chk("hold_type",  tlp_if.o_tlp_type,  prev_type);
                chk("hold_sop",   tlp_if.o_tlp_sop,   prev_sop);
                chk("hold_last",  tlp_if.o_tlp_last,  prev_last);
                chk("hold_hdr",   tlp_if.o_tlp_hdr,   prev_hdr);
                chk("hold_data",  tlp_if.o_tlp_data,  prev_data);
            end
            if (tlp_if.o_tlp_valid && tlp_if.i_tlp_ready) begin
                beats_acc++;
                if (sb.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    e = sb.pop_front();
                    ec = (e.typ == 2'd0) ? p_ctrl : ((e.typ == 2'd1) ? np_ctrl : c_ctrl);
                    chk("beat_type", tlp_if.o_tlp_type, e.typ);
                    chk("beat_sop",  tlp_if.o_tlp_sop,  e.sop);
                    chk("beat_last", tlp_if.o_tlp_last, e.last);
                    chk("beat_dvld", tlp_if.o_tlp_data_vld, e.dvld);
                    chk("pop_on_accept", ec, {4'b0, e.dvld, e.sop});
                    if (e.sop)  chk("beat_hdr",  tlp_if.o_tlp_hdr,  e.hdr);
                    if (e.dvld) chk("beat_data", tlp_if.o_tlp_data, e.data);
                end
            end
            prev_stall = tlp_if.o_tlp_valid && !tlp_if.i_tlp_ready;
            prev_type  = tlp_if.o_tlp_type;
            prev_sop   = tlp_if.o_tlp_sop;
            prev_last  = tlp_if.o_tlp_last;
            prev_hdr   = tlp_if.o_tlp_hdr;
            prev_data  = tlp_if.o_tlp_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic chk_quiet(input string tag);
        chk({tag, "_valid"}, tlp_if.o_tlp_valid, 0);
        chk({tag, "_sop"},   tlp_if.o_tlp_sop, 0);
        chk({tag, "_last"},  tlp_if.o_tlp_last, 0);
        chk({tag, "_dvld"},  tlp_if.o_tlp_data_vld, 0);
        chk({tag, "_type"},  tlp_if.o_tlp_type, 0);
        chk({tag, "_hdr"},   tlp_if.o_tlp_hdr, 0);
        chk({tag, "_data"},  tlp_if.o_tlp_data, 0);
        chk({tag, "_ctrl"},  {p_ctrl, np_ctrl, c_ctrl}, 0);
    endtask

    initial begin
        int h0, d0, b0, c;
        tlp_if.i_tlp_ready = 1'b0;
        refresh();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk_quiet("reset");
        tlp_if.i_tlp_ready = 1'b1;

        // Posted write, 64 DW: header beat plus one data beat.
        h0 = hpops[0]; d0 = dpops[0];
        push_tlp(0, 1'b1, 10'd64, 8'h01, -1);
        drain("t1", 200);
        chk("t1_p_hdr_pops",  hpops[0] - h0, 1);
        chk("t1_p_data_pops", dpops[0] - d0, 2);

        // Non-posted read without data: single beat, one header pop.
        h0 = hpops[1]; d0 = dpops[1]; np_ctrl_hi = 0;
        push_tlp(1, 1'b0, 10'd1, 8'h02, -1);
        drain("t2", 200);
        chk("t2_np_ctrl_cycles", np_ctrl_hi, 1);
        chk("t2_np_hdr_pops",  hpops[1] - h0, 1);
        chk("t2_np_data_pops", dpops[1] - d0, 0);

        // Completion with length 0 (1024 DW): 32 beats.
        h0 = hpops[2]; d0 = dpops[2]; b0 = beats_acc;
        push_tlp(2, 1'b1, 10'd0, 8'h03, -1);
        drain("t3", 400);
        chk("t3_c_hdr_pops",  hpops[2] - h0, 1);
        chk("t3_c_data_pops", dpops[2] - d0, 32);
        chk("t3_beats",       beats_acc - b0, 32);

        // All classes pending at once, starting from a fresh pointer.
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
`ifdef TL_RX_VC_ARB_P_PRIORITY_EN
        push_tlp(0, 1'b1, 10'd32, 8'h41, -1);
        push_tlp(0, 1'b0, 10'd1,  8'h44, -1);
        push_tlp(2, 1'b1, 10'd40, 8'h43, -1);
        push_tlp(1, 1'b0, 10'd1,  8'h42, -1);
`else
        push_tlp(0, 1'b1, 10'd32, 8'h41, -1);
        push_tlp(1, 1'b0, 10'd1,  8'h42, -1);
        push_tlp(2, 1'b1, 10'd40, 8'h43, -1);
        push_tlp(0, 1'b0, 10'd1,  8'h44, -1);
`endif
        drain("t4", 300);

        // Posted 96 DW with toggling ready and a data gap after the header beat.
        h0 = hpops[0]; d0 = dpops[0]; b0 = beats_acc;
        push_tlp(0, 1'b1, 10'd96, 8'h05, 1);
        c = 0;
        while (busy() && c < 100) begin
            @(posedge clk);
            #2;
            tlp_if.i_tlp_ready = 1'((c & 1) != 0);
            if (c == 7) chk("t5_gap_valid_low", tlp_if.o_tlp_valid, 0);
            if (c == 8) begin
                push_beat(0, 8'h05, 1);
                push_beat(0, 8'h05, 2);
                refresh();
            end
            c++;
        end
        if (c >= 100) chk("t5_timeout", 0, 1);
        tlp_if.i_tlp_ready = 1'b1;
        drain("t5", 50);
        chk("t5_p_hdr_pops",  hpops[0] - h0, 1);
        chk("t5_p_data_pops", dpops[0] - d0, 3);
        chk("t5_beats",       beats_acc - b0, 3);

        // Reset while beat 3 of an 8-beat posted write is on the bus.
        h0 = hpops[0]; d0 = dpops[0]; b0 = beats_acc;
        push_tlp(0, 1'b1, 10'd256, 8'h06, -1);
        c = 0;
        while (beats_acc - b0 < 2 && c < 100) begin
            @(posedge clk);
            c++;
        end
        if (c >= 100) chk("t6_timeout", 0, 1);
        #2;
        tlp_if.i_tlp_ready = 1'b0;
        #1;
        chk("t6_beat3_valid", tlp_if.o_tlp_valid, 1);
        rst = 1'b1;
        @(posedge clk);
        #2;
        chk_quiet("t6_after_rst");
        chk("t6_p_data_pops", dpops[0] - d0, 2);
        chk("t6_p_hdr_pops",  hpops[0] - h0, 1);
        rst = 1'b0;
        sb.delete();
        p_hq.delete();
        p_dq.delete();
        refresh();
        // Pointer back at P: P wins over NP even though P was granted last.
        tlp_if.i_tlp_ready = 1'b1;
        push_tlp(0, 1'b0, 10'd1, 8'h07, -1);
        push_tlp(1, 1'b0, 10'd1, 8'h08, -1);
        drain("t6_ptr", 100);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
